// File: rtl/issue_pkg.sv
// Shared issue-stage definitions: default issue width and a one-hot to index
// helper used by checkers and benches.
package issue_pkg;

   localparam int ISSUE_N = 8;

   // Index of the lowest set bit, or -1 when the vector is empty.
   function automatic int onehot_to_idx(input logic [63:0] vec);
      int result;
      result = -1;
      for (int i = 63; i >= 0; i--) begin
         if (vec[i]) result = i;
      end
      return result;
   endfunction

endpackage

// File: rtl/prio_encoder.sv
// Combinational lowest-set-bit priority encoder with an any-request flag.
module prio_encoder #(
   parameter int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         any
);

   // Scanning downward lets the lowest set bit win the last assignment.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_grant_encoder.sv
// Registered round-robin arbiter: picks one request fairly and presents it as
// an index plus one-hot behind a valid/ready handshake.
module rr_grant_encoder
   import issue_pkg::*;
#(
   parameter int N = ISSUE_N,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [N-1:0] req,
   input  logic         enable,
   output logic [W-1:0] grant_idx,
   output logic [N-1:0] grant_onehot,
   output logic         grant_valid,
   input  logic         grant_ready
);

   logic [W-1:0] grant_idx_reg;
   logic [N-1:0] grant_onehot_reg;
   logic         grant_valid_reg;
   logic [W-1:0] ptr_reg;
   logic [W-1:0] ptr_next;

   logic         acc;
   logic         load;
   logic [N-1:0] eff_req;
   logic [N-1:0] ptr_mask;
   logic [N-1:0] masked_req;
   logic [W-1:0] masked_idx;
   logic         masked_any;
   logic [W-1:0] full_idx;
   logic         full_any;
   logic [W-1:0] sel;
   logic [N-1:0] sel_onehot;

   assign acc = grant_valid_reg & grant_ready;

   // The held entry is hidden so an accepted grant is never reissued at once.
   assign eff_req = req & ~(grant_valid_reg ? grant_onehot_reg : '0);

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_bits
         localparam logic [W-1:0] BIT_IDX = W'(gi);
         assign ptr_mask[gi]   = (BIT_IDX >= ptr_reg);
         assign sel_onehot[gi] = (sel == BIT_IDX);
      end
   endgenerate

   assign masked_req = eff_req & ptr_mask;

   prio_encoder #(.N(N)) u_masked_enc (
      .req (masked_req),
      .idx (masked_idx),
      .any (masked_any)
   );

   prio_encoder #(.N(N)) u_full_enc (
      .req (eff_req),
      .idx (full_idx),
      .any (full_any)
   );

   assign sel      = masked_any ? masked_idx : full_idx;
   assign load     = enable & full_any & (~grant_valid_reg | acc);
   assign ptr_next = (sel == W'(N - 1)) ? '0 : sel + W'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant_idx_reg    <= '0;
         grant_onehot_reg <= '0;
         grant_valid_reg  <= 1'b0;
         ptr_reg          <= '0;
      end else if (load) begin
         grant_idx_reg    <= sel;
         grant_onehot_reg <= sel_onehot;
         grant_valid_reg  <= 1'b1;
         ptr_reg          <= ptr_next;
      end else if (acc) begin
         grant_onehot_reg <= '0;
         grant_valid_reg  <= 1'b0;
      end
   end

   assign grant_idx    = grant_idx_reg;
   assign grant_onehot = grant_onehot_reg;
   assign grant_valid  = grant_valid_reg;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed, table-driven bench for rr_grant_encoder at N=8 and N=5.
module tb_rr_grant_encoder;
   import issue_pkg::*;

   typedef struct {
      logic [7:0] req;
      logic       en;
      logic       rdy;
      logic       v;
      logic [2:0] idx;
      logic [7:0] oh;
   } vec_t;

   logic       clk;
   logic       rst_a_n, rst_b_n;
   logic [7:0] req_a;
   logic       en_a, rdy_a;
   logic [2:0] idx_a;
   logic [7:0] oh_a;
   logic       v_a;
   logic [4:0] req_b;
   logic       en_b, rdy_b;
   logic [2:0] idx_b;
   logic [4:0] oh_b;
   logic       v_b;

   int checks = 0;
   int errors = 0;
   vec_t tbl[$];

   rr_grant_encoder #(.N(8)) dut_a (
      .clk(clk), .reset_n(rst_a_n), .req(req_a), .enable(en_a),
      .grant_idx(idx_a), .grant_onehot(oh_a), .grant_valid(v_a), .grant_ready(rdy_a)
   );

   rr_grant_encoder #(.N(5)) dut_b (
      .clk(clk), .reset_n(rst_b_n), .req(req_b), .enable(en_b),
      .grant_idx(idx_b), .grant_onehot(oh_b), .grant_valid(v_b), .grant_ready(rdy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic [7:0] r, input logic e, input logic rd,
                               input logic v, input logic [2:0] i, input logic [7:0] o);
      vec_t t;
      t.req = r; t.en = e; t.rdy = rd; t.v = v; t.idx = i; t.oh = o;
      tbl.push_back(t);
   endfunction

   initial begin
      rst_a_n = 1'b0; rst_b_n = 1'b0;
      req_a = 8'hFF; en_a = 1'b1; rdy_a = 1'b1;
      req_b = 5'h00; en_b = 1'b1; rdy_b = 1'b1;

      // Rotation 0..7 then wrap to 0..3
      for (int i = 0; i < 8; i++) add(8'hFF, 1, 1, 1, 3'(i), 8'h01 << i);
      for (int i = 0; i < 4; i++) add(8'hFF, 1, 1, 1, 3'(i), 8'h01 << i);
      // Stall on idx 3 while req changes
      for (int i = 0; i < 4; i++) add(8'h81, 1, 0, 1, 3'd3, 8'h08);
      add(8'h81, 1, 1, 1, 3'd7, 8'h80);
      add(8'h81, 1, 1, 1, 3'd0, 8'h01);
      // Move ptr to 6, then sparse wrap
      add(8'h20, 1, 1, 1, 3'd5, 8'h20);
      add(8'h05, 1, 1, 1, 3'd0, 8'h01);
      add(8'h05, 1, 1, 1, 3'd2, 8'h04);
      // Enable low: accept idx 5, then nothing loads
      add(8'h20, 1, 1, 1, 3'd5, 8'h20);
      add(8'hFF, 0, 1, 0, 3'd5, 8'h00);
      add(8'hFF, 0, 1, 0, 3'd5, 8'h00);
      add(8'hFF, 1, 1, 1, 3'd6, 8'h40);
      // Single continuous requester: granted every other cycle
      add(8'h02, 1, 1, 1, 3'd1, 8'h02);
      add(8'h02, 1, 1, 0, 3'd1, 8'h00);
      add(8'h02, 1, 1, 1, 3'd1, 8'h02);
      // Stall holds even with enable low and req gone
      add(8'h00, 0, 0, 1, 3'd1, 8'h02);

      #1;
      chk("rst_valid", 64'(v_a), 64'd0);
      chk("rst_idx", 64'(idx_a), 64'd0);
      chk("rst_onehot", 64'(oh_a), 64'd0);
      @(posedge clk); #1;
      chk("rst_hold_valid", 64'(v_a), 64'd0);
      rst_a_n = 1'b1;

      foreach (tbl[k]) begin
         req_a = tbl[k].req; en_a = tbl[k].en; rdy_a = tbl[k].rdy;
         @(posedge clk); #1;
         $display("vec %0d: req=%h en=%b rdy=%b -> v=%b idx=%0d oh=%h",
                  k, tbl[k].req, tbl[k].en, tbl[k].rdy, v_a, idx_a, oh_a);
         chk($sformatf("vec%0d_valid", k), 64'(v_a), 64'(tbl[k].v));
         chk($sformatf("vec%0d_onehot", k), 64'(oh_a), 64'(tbl[k].oh));
         if (tbl[k].v) begin
            chk($sformatf("vec%0d_idx", k), 64'(idx_a), 64'(tbl[k].idx));
            chk($sformatf("vec%0d_oh2idx", k), 64'(onehot_to_idx(64'(oh_a))), 64'(tbl[k].idx));
         end else begin
            chk($sformatf("vec%0d_idx_held", k), 64'(idx_a), 64'(tbl[k].idx));
         end
      end

      // N=5: reset state, then continuous rotation 0..4 with wrap
      chk("b_rst_valid", 64'(v_b), 64'd0);
      chk("b_rst_onehot", 64'(oh_b), 64'd0);
      rst_b_n = 1'b1;
      req_b = 5'h1F;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         $display("n5 step %0d: v=%b idx=%0d oh=%h", i, v_b, idx_b, oh_b);
         chk($sformatf("n5_%0d_valid", i), 64'(v_b), 64'd1);
         chk($sformatf("n5_%0d_idx", i), 64'(idx_b), 64'(i % 5));
         chk($sformatf("n5_%0d_onehot", i), 64'(oh_b), 64'(5'h01 << (i % 5)));
      end

      // Asynchronous reset mid-stream clears outputs before the next edge
      #2 rst_b_n = 1'b0;
      #1;
      $display("n5 async reset: v=%b idx=%0d oh=%h", v_b, idx_b, oh_b);
      chk("n5_async_valid", 64'(v_b), 64'd0);
      chk("n5_async_idx", 64'(idx_b), 64'd0);
      chk("n5_async_onehot", 64'(oh_b), 64'd0);
      @(posedge clk); #1;
      rst_b_n = 1'b1;
      @(posedge clk); #1;
      chk("n5_post_rst_idx", 64'(idx_b), 64'd0);
      chk("n5_post_rst_valid", 64'(v_b), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
